// File: rtl/fp_operand_gen.sv
// Seedable xorshift64 source of non-negative finite FP operand pairs for the mul/div datapath.
// Pairs are delivered over a valid/ready handshake; all outputs are registered.
module fp_operand_gen #(
  parameter int unsigned EXP_W      = 8,
  parameter int unsigned MAN_W      = 23,
  parameter int unsigned CNT_W      = 16,
  parameter logic [63:0] SEED       = 64'h0000_0000_0000_0001,
  parameter bit          NO_SUBNORM = 1'b0
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic                   start,
  input  logic [2:0]             mode,
  input  logic [CNT_W-1:0]       count,
  input  logic                   seed_load,
  input  logic [63:0]            seed,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   a,
  output logic [EXP_W+MAN_W:0]   b,
  output logic                   sel,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_W-1:0]       remaining
);

  localparam int unsigned W = 1 + EXP_W + MAN_W;

  if (W > 64) begin : g_width_check
    $error("fp_operand_gen: operand width 1+EXP_W+MAN_W must not exceed 64");
  end
  if (SEED == 64'd0) begin : g_seed_check
    $error("fp_operand_gen: SEED must be nonzero");
  end

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state;
  logic [63:0]      s;
  logic [2:0]       mode_q;

  logic [63:0]      seed_eff;
  logic [63:0]      base;
  logic [63:0]      s1;
  logic [63:0]      s2;
  logic [W-1:0]     ca;
  logic [W-1:0]     cb;
  logic             rsel;
  logic [2:0]       mode_eff;
  logic [W-1:0]     nxt_a;
  logic [W-1:0]     nxt_b;
  logic             nxt_sel;
  logic [CNT_W-1:0] rem_dec;
  logic             accept;

  function automatic logic [63:0] xs(input logic [63:0] x);
    logic [63:0] t;
    t = x;
    t = t ^ (t << 13);
    t = t ^ (t >> 7);
    t = t ^ (t << 17);
    return t;
  endfunction

  // Clear sign, keep exponent out of the Inf/NaN code and optionally off zero.
  function automatic logic [W-1:0] constrain(input logic [W-1:0] r);
    logic [EXP_W-1:0] e;
    e = r[W-2 -: EXP_W];
    if (e == '1) begin
      e = e - EXP_W'(1);
    end else if (NO_SUBNORM && (e == '0)) begin
      e = EXP_W'(1);
    end
    return {1'b0, e, r[MAN_W-1:0]};
  endfunction

  // A seed load in the same IDLE cycle as start feeds the first pair directly.
  always_comb begin
    seed_eff = (seed == 64'd0) ? SEED : seed;
    base     = ((state == IDLE) && seed_load) ? seed_eff : s;
    s1       = xs(base);
    s2       = xs(s1);
    ca       = constrain(s1[W-1:0]);
    cb       = constrain(s2[W-1:0]);
    rsel     = s1[63];
    mode_eff = (state == IDLE) ? mode : mode_q;
    nxt_a    = ca;
    nxt_b    = cb;
    nxt_sel  = rsel;
    case (mode_eff)
      3'd1: nxt_sel = 1'b0;
      3'd2: nxt_sel = 1'b1;
      3'd3: begin
        if (ca < cb) begin
          nxt_a = cb;
          nxt_b = ca;
        end
      end
      3'd4: begin
        if (ca > cb) begin
          nxt_a = cb;
          nxt_b = ca;
        end
      end
      default: nxt_sel = rsel;
    endcase
  end

  always_comb begin
    rem_dec = remaining - CNT_W'(1);
    accept  = out_valid && out_ready;
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state     <= IDLE;
      s         <= SEED;
      mode_q    <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      remaining <= '0;
      a         <= '0;
      b         <= '0;
      sel       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (seed_load) begin
            s <= seed_eff;
          end
          if (start) begin
            if (count != '0) begin
              s         <= s2;
              a         <= nxt_a;
              b         <= nxt_b;
              sel       <= nxt_sel;
              mode_q    <= mode;
              remaining <= count;
              out_valid <= 1'b1;
              busy      <= 1'b1;
              state     <= RUN;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            remaining <= rem_dec;
            if (rem_dec != '0) begin
              s   <= s2;
              a   <= nxt_a;
              b   <= nxt_b;
              sel <= nxt_sel;
            end else begin
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_operand_gen.sv
// Directed-sequence bench for fp_operand_gen with a queue-free arithmetic reference model
// of the xorshift stream, operand constraint and mode ordering rules.
module tb_fp_operand_gen;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int CNT_W = 16;
  localparam logic [63:0] SEED = 64'h0000_0000_0000_0001;

  logic        clk = 1'b0;
  logic        arst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  mode = '0;
  logic [15:0] count = '0;
  logic        seed_load = 1'b0;
  logic [63:0] seed = '0;
  logic        out_ready = 1'b0;

  logic        out_valid, sel, busy, done;
  logic [31:0] a, b;
  logic [15:0] remaining;
  logic        out_valid2, sel2, busy2, done2;
  logic [31:0] a2, b2;
  logic [15:0] remaining2;

  int compared = 0;
  int mismatched = 0;

  longint unsigned ms;
  longint unsigned ea, eb, ea2, eb2;
  bit es, es2;
  bit first_const = 1'b0;
  bit exp_chk = 1'b0;

  fp_operand_gen #(.EXP_W(EXP_W), .MAN_W(MAN_W), .CNT_W(CNT_W), .SEED(SEED), .NO_SUBNORM(1'b0)) dut (
    .clk(clk), .arst(arst), .start(start), .mode(mode), .count(count),
    .seed_load(seed_load), .seed(seed), .out_valid(out_valid), .out_ready(out_ready),
    .a(a), .b(b), .sel(sel), .busy(busy), .done(done), .remaining(remaining)
  );

  fp_operand_gen #(.EXP_W(EXP_W), .MAN_W(MAN_W), .CNT_W(CNT_W), .SEED(SEED), .NO_SUBNORM(1'b1)) dut_ns (
    .clk(clk), .arst(arst), .start(start), .mode(mode), .count(count),
    .seed_load(seed_load), .seed(seed), .out_valid(out_valid2), .out_ready(out_ready),
    .a(a2), .b(b2), .sel(sel2), .busy(busy2), .done(done2), .remaining(remaining2)
  );

  always #5 clk = ~clk;

  function automatic longint unsigned m_xs(input longint unsigned x);
    longint unsigned t;
    t = x;
    t = t ^ (t << 13);
    t = t ^ (t >> 7);
    t = t ^ (t << 17);
    return t;
  endfunction

  function automatic longint unsigned m_con(input longint unsigned raw, input bit nosub);
    longint unsigned man, e;
    man = raw % (64'd1 << MAN_W);
    e   = (raw >> MAN_W) % 64'd256;
    if (e == 64'd255) e = 64'd254;
    else if (nosub && e == 64'd0) e = 64'd1;
    return e * (64'd1 << MAN_W) + man;
  endfunction

  task automatic m_form(input int md, input longint unsigned ca, input longint unsigned cb,
                        input bit rs, output longint unsigned oa, output longint unsigned ob,
                        output bit os);
    oa = ca; ob = cb; os = rs;
    case (md)
      1: os = 1'b0;
      2: os = 1'b1;
      3: begin oa = (ca > cb) ? ca : cb; ob = (ca > cb) ? cb : ca; end
      4: begin oa = (ca < cb) ? ca : cb; ob = (ca < cb) ? cb : ca; end
      default: ;
    endcase
  endtask

  task automatic m_pair(input int md);
    longint unsigned s1, s2, ra, rb;
    bit rs;
    s1 = m_xs(ms);
    s2 = m_xs(s1);
    ms = s2;
    ra = s1 % (64'd1 << 32);
    rb = s2 % (64'd1 << 32);
    rs = s1[63];
    m_form(md, m_con(ra, 1'b0), m_con(rb, 1'b0), rs, ea, eb, es);
    m_form(md, m_con(ra, 1'b1), m_con(rb, 1'b1), rs, ea2, eb2, es2);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_run(input int md, input int cnt, input int ready_pct, input int stall_at,
                        input bit jitter, input bit ld, input longint unsigned sd);
    int got, budget, stall_n;
    bit rdy;
    if (ld) begin
      seed_load = 1'b1;
      seed = sd;
      ms = (sd == 0) ? SEED : sd;
    end
    mode = 3'(md);
    count = 16'(cnt);
    start = 1'b1;
    step();
    start = 1'b0;
    seed_load = 1'b0;
    m_pair(md);
    got = 0;
    stall_n = 0;
    budget = cnt * 20 + 50;
    while (got < cnt && budget > 0) begin
      budget--;
      chk("valid", 64'(out_valid), 64'd1);
      chk("busy", 64'(busy), 64'd1);
      chk("remaining", 64'(remaining), 64'(cnt - got));
      chk("a", 64'(a), ea);
      chk("b", 64'(b), eb);
      chk("sel", 64'(sel), 64'(es));
      chk("a_nosub", 64'(a2), ea2);
      chk("b_nosub", 64'(b2), eb2);
      chk("sign_clear", 64'({a[31], b[31]}), 64'd0);
      chk("no_inf_exp", 64'({a[30:23] == 8'hFF, b[30:23] == 8'hFF}), 64'd0);
      if (md == 3) chk("a_ge_b", 64'(a >= b), 64'd1);
      if (md == 4) chk("b_ge_a", 64'(b >= a), 64'd1);
      if (md == 1) chk("sel_mul", 64'(sel), 64'd0);
      if (md == 2) chk("sel_div", 64'(sel), 64'd1);
      if (got == 0 && first_const) chk("first_a_const", 64'(a), 64'h40822041);
      if (got == 0 && exp_chk) begin
        chk("exp_zero_kept", 64'(a[30:23]), 64'd0);
        chk("exp_nosub_one", 64'(a2[30:23]), 64'd1);
      end
      rdy = (ready_pct >= 100) ? 1'b1 : ($urandom_range(99) < ready_pct);
      if (stall_at >= 0 && got == stall_at && stall_n < 5) begin
        rdy = 1'b0;
        stall_n++;
      end
      out_ready = rdy;
      if (jitter) begin
        start = 1'($urandom);
        mode = 3'($urandom);
        count = 16'($urandom);
        seed_load = 1'($urandom);
        seed = {$urandom, $urandom};
      end
      step();
      if (rdy) begin
        got++;
        if (got < cnt) m_pair(md);
      end
    end
    if (got < cnt) chk("run_timeout", 64'(got), 64'(cnt));
    start = 1'b0;
    seed_load = 1'b0;
    out_ready = 1'b0;
    chk("done_pulse", 64'(done), 64'd1);
    chk("valid_low_end", 64'(out_valid), 64'd0);
    chk("busy_low_end", 64'(busy), 64'd0);
    chk("remaining_end", 64'(remaining), 64'd0);
    step();
    chk("done_one_cycle", 64'(done), 64'd0);
    first_const = 1'b0;
    exp_chk = 1'b0;
  endtask

  initial begin
    longint unsigned sd;
    int tries;
    bit found;

    ms = SEED;
    #3;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_remaining", 64'(remaining), 64'd0);
    chk("rst_ab", 64'({a, b}), 64'd0);
    chk("rst_sel", 64'(sel), 64'd0);
    @(negedge clk);
    arst = 1'b1;
    step();

    first_const = 1'b1;
    do_run(0, 1, 100, -1, 1'b0, 1'b0, 0);

    do_run(3, 1000, 50, -1, 1'b1, 1'b1, {$urandom, $urandom} | 64'd1);
    do_run(4, 1000, 50, -1, 1'b0, 1'b0, 0);

    do_run(0, 20, 100, 8, 1'b0, 1'b0, 0);
    do_run(2, 30, 70, -1, 1'b0, 1'b0, 0);
    do_run(1, 30, 70, -1, 1'b0, 1'b0, 0);
    do_run(6, 30, 70, -1, 1'b0, 1'b0, 0);

    // zero seed falls back to SEED
    seed_load = 1'b1;
    seed = 64'd0;
    step();
    seed_load = 1'b0;
    ms = SEED;
    first_const = 1'b1;
    do_run(0, 5, 100, -1, 1'b0, 1'b0, 0);

    seed_load = 1'b1;
    seed = 64'h0123_4567_89AB_CDEF;
    step();
    seed_load = 1'b0;
    ms = 64'h0123_4567_89AB_CDEF;
    do_run(5, 10, 60, -1, 1'b0, 1'b0, 0);

    mode = 3'd0;
    count = 16'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("cnt0_done", 64'(done), 64'd1);
    chk("cnt0_valid", 64'(out_valid), 64'd0);
    chk("cnt0_busy", 64'(busy), 64'd0);
    step();
    chk("cnt0_done_clear", 64'(done), 64'd0);
    chk("cnt0_valid_after", 64'(out_valid), 64'd0);

    found = 1'b0;
    sd = 64'd1;
    for (tries = 0; tries < 100000 && !found; tries++) begin
      sd = {$urandom, $urandom};
      if (sd != 0 && ((m_xs(sd) >> MAN_W) % 64'd256) == 64'd0) found = 1'b1;
    end
    chk("seed_search", 64'(found), 64'd1);
    exp_chk = found;
    do_run(0, 1, 100, -1, 1'b0, 1'b1, sd);

    // abort a run with 7 pairs outstanding
    ms = SEED;
    arst = 1'b0;
    #2;
    arst = 1'b1;
    step();
    mode = 3'd0;
    count = 16'd20;
    start = 1'b1;
    step();
    start = 1'b0;
    out_ready = 1'b1;
    repeat (13) step();
    out_ready = 1'b0;
    chk("pre_abort_remaining", 64'(remaining), 64'd7);
    #2;
    arst = 1'b0;
    #1;
    chk("abort_valid", 64'(out_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_remaining", 64'(remaining), 64'd0);
    chk("abort_ab", 64'({a, b}), 64'd0);
    chk("abort_sel", 64'(sel), 64'd0);
    step();
    chk("abort_done_held", 64'(done), 64'd0);
    @(negedge clk);
    arst = 1'b1;
    step();
    chk("post_abort_done", 64'(done), 64'd0);
    chk("post_abort_valid", 64'(out_valid), 64'd0);
    ms = SEED;
    first_const = 1'b1;
    do_run(0, 3, 100, -1, 1'b0, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
